// File: rtl/pig_game_if.sv
// Interface bundling the die-roller/button inputs and score-display outputs of the Pig game.
// master drives die value and buttons; slave is the game engine.
// No flow control: levels in, registered levels/pulses out.
interface pig_game_if #(
  parameter int SCORE_W = 8
);
  logic [2:0]         num;
  logic               choose;
  logic               hold;
  logic               new_game;
  logic               player;
  logic [SCORE_W-1:0] turn_total;
  logic [SCORE_W-1:0] score0;
  logic [SCORE_W-1:0] score1;
  logic [2:0]         last_roll;
  logic               bust;
  logic               game_over;
  logic               winner;

  modport master (
    output num, choose, hold, new_game,
    input  player, turn_total, score0, score1, last_roll, bust, game_over, winner
  );

  modport slave (
    input  num, choose, hold, new_game,
    output player, turn_total, score0, score1, last_roll, bust, game_over, winner
  );
endinterface

// File: rtl/pig_game.sv
// Two-player Pig game engine: consumes committed die rolls and hold presses, tracks turn/banked scores and winner.
// Latency: one clock from the sampled input edge to updated outputs.
// Backpressure: none; every qualifying edge is consumed, events in WIN are discarded.
module pig_game #(
  parameter int SCORE_W = 8,
  parameter int TARGET  = 100
) (
  input logic      clk,
  input logic      rst_n,
  pig_game_if.slave bus
);

  typedef enum logic {S_PLAY, S_WIN} state_t;

  localparam logic [SCORE_W-1:0] TARGET_V = SCORE_W'(TARGET);

  state_t             r_state;
  logic               r_choose_q;
  logic               r_hold_q;
  logic               r_player;
  logic [SCORE_W-1:0] r_turn;
  logic [SCORE_W-1:0] r_score0;
  logic [SCORE_W-1:0] r_score1;
  logic [2:0]         r_last;
  logic               r_bust;
  logic               r_game_over;
  logic               r_winner;

  logic               w_num_ok;
  logic               w_roll_ev;
  logic               w_hold_ev;
  logic [SCORE_W-1:0] w_cur_score;
  logic [SCORE_W-1:0] w_turn_add;
  logic [SCORE_W-1:0] w_bank;

  // Unsigned add that clamps at all-ones instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [SCORE_W-1:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

  // Rising edges only; die values 0 and 7 are not legal faces and are ignored.
  assign w_num_ok    = (bus.num != 3'd0) && (bus.num != 3'd7);
  assign w_roll_ev   = bus.choose & ~r_choose_q & w_num_ok;
  assign w_hold_ev   = bus.hold & ~r_hold_q;
  assign w_cur_score = r_player ? r_score1 : r_score0;
  assign w_turn_add  = sat_add(r_turn, SCORE_W'(bus.num));
  assign w_bank      = sat_add(w_cur_score, r_turn);

  // Game FSM plus edge-detect history; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_PLAY;
      // Start high so buttons already held at reset release do not count as presses.
      r_choose_q  <= 1'b1;
      r_hold_q    <= 1'b1;
      r_player    <= 1'b0;
      r_turn      <= '0;
      r_score0    <= '0;
      r_score1    <= '0;
      r_last      <= 3'd0;
      r_bust      <= 1'b0;
      r_game_over <= 1'b0;
      r_winner    <= 1'b0;
    end else begin
      r_choose_q <= bus.choose;
      r_hold_q   <= bus.hold;
      r_bust     <= 1'b0;
      if (bus.new_game) begin
        r_state     <= S_PLAY;
        r_player    <= 1'b0;
        r_turn      <= '0;
        r_score0    <= '0;
        r_score1    <= '0;
        r_last      <= 3'd0;
        r_game_over <= 1'b0;
        r_winner    <= 1'b0;
      end else begin
        case (r_state)
          S_PLAY: begin
            if (w_roll_ev) begin
              // A roll wins over a simultaneous hold; the hold must be pressed again.
              r_last <= bus.num;
              if (bus.num == 3'd1) begin
                r_turn   <= '0;
                r_player <= ~r_player;
                r_bust   <= 1'b1;
              end else begin
                r_turn <= w_turn_add;
              end
            end else if (w_hold_ev) begin
              if (r_player) r_score1 <= w_bank;
              else          r_score0 <= w_bank;
              r_turn <= '0;
              if (w_bank >= TARGET_V) begin
                r_state     <= S_WIN;
                r_game_over <= 1'b1;
                r_winner    <= r_player;
              end else begin
                r_player <= ~r_player;
              end
            end
          end
          default: ; // S_WIN: everything frozen until new_game or reset
        endcase
      end
    end
  end

  assign bus.player     = r_player;
  assign bus.turn_total = r_turn;
  assign bus.score0     = r_score0;
  assign bus.score1     = r_score1;
  assign bus.last_roll  = r_last;
  assign bus.bust       = r_bust;
  assign bus.game_over  = r_game_over;
  assign bus.winner     = r_winner;

endmodule

// File: tb/tb_pig_game.sv
// Scoreboard bench for pig_game: two instances (8-bit/TARGET 20 and 4-bit/TARGET 15).
// Stimulus pushes hand-computed expected snapshots tagged with the cycle they must appear.
// Monitor compares on each falling edge.
module tb_pig_game;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pig_game_if #(.SCORE_W(8)) ia ();
  pig_game_if #(.SCORE_W(4)) ib ();

  pig_game #(.SCORE_W(8), .TARGET(20)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  pig_game #(.SCORE_W(4), .TARGET(15)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

  typedef struct {
    int          cyc;
    int          w;
    string       name;
    logic [30:0] v;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc++;

  function automatic logic [30:0] pack(input int p, input int t, input int s0, input int s1,
                                       input int l, input int b, input int g, input int wn);
    logic [30:0] r;
    r = {p[0], t[7:0], s0[7:0], s1[7:0], l[2:0], b[0], g[0], wn[0]};
    return r;
  endfunction

  function automatic logic [30:0] observe(input int w);
    logic [30:0] r;
    if (w == 0)
      r = {ia.player, ia.turn_total, ia.score0, ia.score1, ia.last_roll, ia.bust, ia.game_over, ia.winner};
    else
      r = {ib.player, 4'b0, ib.turn_total, 4'b0, ib.score0, 4'b0, ib.score1,
           ib.last_roll, ib.bust, ib.game_over, ib.winner};
    return r;
  endfunction

  // Monitor: pop every expectation due at this cycle and compare.
  exp_t        m_e;
  logic [30:0] m_act;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      m_e = q.pop_front();
      n_checks++;
      if (m_e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: check missed (due cycle %0d, now %0d)", m_e.name, m_e.cyc, cyc);
      end else begin
        m_act = observe(m_e.w);
        if (m_act !== m_e.v) begin
          n_fail++;
          $display("FAIL %s: got p=%0d t=%0d s0=%0d s1=%0d last=%0d bust=%0d go=%0d win=%0d, expected p=%0d t=%0d s0=%0d s1=%0d last=%0d bust=%0d go=%0d win=%0d",
                   m_e.name, m_act[30], m_act[29:22], m_act[21:14], m_act[13:6], m_act[5:3],
                   m_act[2], m_act[1], m_act[0], m_e.v[30], m_e.v[29:22], m_e.v[21:14],
                   m_e.v[13:6], m_e.v[5:3], m_e.v[2], m_e.v[1], m_e.v[0]);
        end
      end
    end
  end

  task automatic push(input int tag, input int w, input string nm, input logic [30:0] v);
    exp_t e;
    e.cyc = tag; e.w = w; e.name = nm; e.v = v;
    q.push_back(e);
  endtask

  // One cycle of stimulus on DUT w, called just after a falling edge; expectation due next falling edge.
  task automatic act(input int w, input logic c, input logic h, input logic ng, input logic [2:0] n,
                     input string nm, input int p, input int t, input int s0, input int s1,
                     input int l, input int b, input int g, input int wn);
    if (w == 0) begin
      ia.choose = c; ia.hold = h; ia.new_game = ng; ia.num = n;
    end else begin
      ib.choose = c; ib.hold = h; ib.new_game = ng; ib.num = n;
    end
    push(cyc + 1, w, nm, pack(p, t, s0, s1, l, b, g, wn));
    @(negedge clk);
  endtask

  initial begin
    ia.choose = 1'b0; ia.hold = 1'b0; ia.new_game = 1'b0; ia.num = 3'd0;
    ib.choose = 1'b0; ib.hold = 1'b0; ib.new_game = 1'b0; ib.num = 3'd0;
    repeat (2) @(negedge clk);
    push(cyc + 1, 0, "reset_state", pack(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    act(0, 0, 0, 0, 0, "idle_after_reset", 0, 0, 0, 0, 0, 0, 0, 0);

    // Accumulating rolls for player 0
    act(0, 1, 0, 0, 4, "roll4",      0, 4, 0, 0, 4, 0, 0, 0);
    act(0, 0, 0, 0, 4, "roll4_rel",  0, 4, 0, 0, 4, 0, 0, 0);
    act(0, 1, 0, 0, 5, "roll5",      0, 9, 0, 0, 5, 0, 0, 0);
    act(0, 0, 0, 0, 5, "roll5_rel",  0, 9, 0, 0, 5, 0, 0, 0);
    // Bust on a 1 with turn_total 9
    act(0, 1, 0, 0, 1, "bust",       1, 0, 0, 0, 1, 1, 0, 0);
    act(0, 0, 0, 0, 1, "bust_clear", 1, 0, 0, 0, 1, 0, 0, 0);
    // Player 1 holds with nothing: just passes the turn
    act(0, 0, 1, 0, 1, "empty_hold", 0, 0, 0, 0, 1, 0, 0, 0);
    act(0, 0, 0, 0, 1, "hold_rel",   0, 0, 0, 0, 1, 0, 0, 0);
    // choose held high 10 cycles yields a single roll
    act(0, 1, 0, 0, 3, "held_roll3", 0, 3, 0, 0, 3, 0, 0, 0);
    for (int i = 0; i < 9; i++)
      act(0, 1, 0, 0, 3, "held_no_reroll", 0, 3, 0, 0, 3, 0, 0, 0);
    act(0, 0, 0, 0, 3, "held_rel",   0, 3, 0, 0, 3, 0, 0, 0);
    act(0, 1, 0, 0, 0, "num0_ignored", 0, 3, 0, 0, 3, 0, 0, 0);
    act(0, 0, 0, 0, 0, "num0_rel",   0, 3, 0, 0, 3, 0, 0, 0);
    act(0, 1, 0, 0, 7, "num7_ignored", 0, 3, 0, 0, 3, 0, 0, 0);
    act(0, 0, 0, 0, 7, "num7_rel",   0, 3, 0, 0, 3, 0, 0, 0);
    act(0, 1, 0, 0, 6, "roll6a",     0, 9, 0, 0, 6, 0, 0, 0);
    act(0, 0, 0, 0, 6, "roll6a_rel", 0, 9, 0, 0, 6, 0, 0, 0);
    act(0, 1, 0, 0, 6, "roll6b",     0, 15, 0, 0, 6, 0, 0, 0);
    act(0, 0, 0, 0, 6, "roll6b_rel", 0, 15, 0, 0, 6, 0, 0, 0);
    // Player 0 banks 15
    act(0, 0, 1, 0, 6, "bank15",     1, 0, 15, 0, 6, 0, 0, 0);
    act(0, 0, 0, 0, 6, "bank15_rel", 1, 0, 15, 0, 6, 0, 0, 0);
    // Player 1: roll and hold in the same cycle -> roll wins, hold dropped
    act(0, 1, 0, 0, 2, "p1_roll2",   1, 2, 15, 0, 2, 0, 0, 0);
    act(0, 0, 0, 0, 2, "p1_roll2_rel", 1, 2, 15, 0, 2, 0, 0, 0);
    act(0, 1, 1, 0, 5, "roll_and_hold", 1, 7, 15, 0, 5, 0, 0, 0);
    act(0, 0, 0, 0, 5, "roll_and_hold_rel", 1, 7, 15, 0, 5, 0, 0, 0);
    act(0, 0, 1, 0, 5, "rehold_bank7", 0, 0, 15, 7, 5, 0, 0, 0);
    act(0, 0, 0, 0, 5, "rehold_rel", 0, 0, 15, 7, 5, 0, 0, 0);
    // Player 0 banks 6 -> 21 >= 20 wins
    act(0, 1, 0, 0, 6, "p0_roll6",   0, 6, 15, 7, 6, 0, 0, 0);
    act(0, 0, 0, 0, 6, "p0_roll6_rel", 0, 6, 15, 7, 6, 0, 0, 0);
    act(0, 0, 1, 0, 6, "win",        0, 0, 21, 7, 6, 0, 1, 0);
    act(0, 0, 0, 0, 6, "win_rel",    0, 0, 21, 7, 6, 0, 1, 0);
    act(0, 1, 0, 0, 5, "win_roll_ign", 0, 0, 21, 7, 6, 0, 1, 0);
    act(0, 0, 0, 0, 5, "win_roll_rel", 0, 0, 21, 7, 6, 0, 1, 0);
    act(0, 0, 1, 0, 5, "win_hold_ign", 0, 0, 21, 7, 6, 0, 1, 0);
    act(0, 0, 0, 0, 5, "win_hold_rel", 0, 0, 21, 7, 6, 0, 1, 0);
    act(0, 1, 0, 0, 1, "win_bust_ign", 0, 0, 21, 7, 6, 0, 1, 0);
    act(0, 0, 0, 0, 1, "win_bust_rel", 0, 0, 21, 7, 6, 0, 1, 0);
    // new_game beats a simultaneous roll edge
    act(0, 1, 0, 1, 5, "new_game",   0, 0, 0, 0, 0, 0, 0, 0);
    act(0, 0, 0, 0, 5, "new_game_rel", 0, 0, 0, 0, 0, 0, 0, 0);
    act(0, 1, 0, 0, 4, "ng_roll4",   0, 4, 0, 0, 4, 0, 0, 0);
    act(0, 0, 0, 0, 4, "ng_roll4_rel", 0, 4, 0, 0, 4, 0, 0, 0);

    // Async reset mid-turn: outputs clear before the next rising edge
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    push(cyc, 0, "async_reset", pack(0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    ia.choose = 1'b1; ia.num = 3'd6;
    rst_n = 1'b1;
    act(0, 1, 0, 0, 6, "choose_high_at_release", 0, 0, 0, 0, 0, 0, 0, 0);
    act(0, 0, 0, 0, 6, "release_rel", 0, 0, 0, 0, 0, 0, 0, 0);
    act(0, 1, 0, 0, 2, "post_reset_roll2", 0, 2, 0, 0, 2, 0, 0, 0);
    act(0, 0, 0, 0, 2, "post_reset_rel", 0, 2, 0, 0, 2, 0, 0, 0);

    // 4-bit instance: saturation at 15, then a 15 bank meets TARGET exactly
    act(1, 1, 0, 0, 6, "b_roll6",    0, 6, 0, 0, 6, 0, 0, 0);
    act(1, 0, 0, 0, 6, "b_rel1",     0, 6, 0, 0, 6, 0, 0, 0);
    act(1, 1, 0, 0, 6, "b_roll12",   0, 12, 0, 0, 6, 0, 0, 0);
    act(1, 0, 0, 0, 6, "b_rel2",     0, 12, 0, 0, 6, 0, 0, 0);
    act(1, 1, 0, 0, 6, "b_sat15",    0, 15, 0, 0, 6, 0, 0, 0);
    act(1, 0, 0, 0, 5, "b_rel3",     0, 15, 0, 0, 6, 0, 0, 0);
    act(1, 1, 0, 0, 5, "b_sat_hold15", 0, 15, 0, 0, 5, 0, 0, 0);
    act(1, 0, 0, 0, 5, "b_rel4",     0, 15, 0, 0, 5, 0, 0, 0);
    act(1, 0, 1, 0, 5, "b_win_at_target", 0, 0, 15, 0, 5, 0, 1, 0);
    act(1, 0, 0, 0, 5, "b_win_rel",  0, 0, 15, 0, 5, 0, 1, 0);

    repeat (3) @(negedge clk);
    while (q.size() > 0) begin
      m_e = q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: never checked (due cycle %0d)", m_e.name, m_e.cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d checks pending", q.size());
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pig_game.md
Name: pig_game

Overview:
- Downstream consumer of the die roller. It takes the committed die value (`num` plus `choose`) and a hold button, and runs a two-player game of Pig.
- It tracks the running turn total, each player's banked score, whose turn it is, bust events and the winner, for the score display stage.
- All game state is registered. Outputs update one clock after the qualifying input edge.

Parameters:
- SCORE_W, 8, width of banked scores and turn total. Values saturate at 2^SCORE_W-1.
- TARGET, 100, winning banked score. Must be ≤ 2^SCORE_W-1.

Ports:
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- num  in  3  die value from roller, valid 1..6
- choose  in  1  roller commit level, high while a value is held
- hold  in  1  bank request level (debounced upstream)
- new_game  in  1  synchronous restart, level
- player  out  1  current player, 0 or 1
- turn_total  out  SCORE_W  points accumulated in the current turn
- score0  out  SCORE_W  banked score, player 0
- score1  out  SCORE_W  banked score, player 1
- last_roll  out  3  most recent accepted die value, 0 if none
- bust  out  1  one-cycle pulse when a 1 is rolled
- game_over  out  1  high in WIN state
- winner  out  1  valid when game_over

Behaviour:
- Reset (rst_n=0, async):
  - state=PLAY; player=0; turn_total=0; score0=0; score1=0; last_roll=0; bust=0; game_over=0; winner=0.
  - choose_q=1 and hold_q=1, so levels already high when reset releases are not edges.
- Edge detect, registered every cycle (choose_q<=choose, hold_q<=hold):
  - roll_ev = choose & ~choose_q & (num in 1..6). A rising choose with num of 0 or 7 is ignored and produces no state change.
  - hold_ev = hold & ~hold_q.
- Latency: an event sampled at edge k updates outputs after edge k. choose held high produces exactly one roll.
- State PLAY:
  - roll_ev, num==1:
    - turn_total<=0; player<=~player; last_roll<=1; bust<=1 for one cycle.
  - roll_ev, num in 2..6:
    - turn_total<=sat(turn_total+num); last_roll<=num.
  - hold_ev (no roll_ev):
    - s = sat(score[player]+turn_total); score[player]<=s; turn_total<=0.
    - If s>=TARGET: state<=WIN, winner<=player, game_over<=1, player unchanged.
    - Else: player<=~player.
    - Hold with turn_total=0 is legal and simply passes the turn.
  - roll_ev and hold_ev in the same cycle:
    - The roll is processed; the hold is dropped.
    - The hold must be re-pressed (new edge) to bank.
- State WIN:
  - roll_ev and hold_ev are ignored.
  - All outputs hold; bust stays 0.
- new_game=1 (any state):
  - Next edge loads the reset values of all outputs and state.
  - choose_q and hold_q sample normally and are not forced to 1.
  - new_game has priority over roll_ev and hold_ev.
- Arithmetic: unsigned, SCORE_W bits. sat() clamps to 2^SCORE_W-1 and never wraps.
- bust is a registered pulse. It deasserts the cycle after assertion unless another bust occurs.
- Asynchronous reset mid-game aborts immediately. No partial bank is retained.

Test Plan:
- TARGET=20, reset, then choose rising edges with num=4, 5, 6 -> turn_total=4, 9, 15. Player stays 0; last_roll=6; scores stay 0.
- Hold choose high for 10 cycles with num=3 -> exactly one roll (turn_total+3). Rising choose with num=0 -> no change.
- turn_total=9, then roll num=1 -> turn_total=0, player=1, bust high for exactly one cycle, score0 unchanged.
- Player 0 turn_total=15, hold edge -> score0=15, turn_total=0, player=1. Later player 0 banks 6 -> score0=21, game_over=1, winner=0. Further rolls and holds leave all outputs fixed.
- Same-cycle choose and hold rising edges with num=5, turn_total=2 -> turn_total=7, no bank. Next hold edge -> score banks 7.
- SCORE_W=4, TARGET=15: accumulate rolls past 15 -> turn_total saturates at 15.
- rst_n pulled low mid-turn -> outputs zero immediately (async). choose high at reset release -> no roll.
- new_game in WIN -> all outputs return to reset values next edge.
